// File: rtl/axis_packet_filter_sf.sv
// Store-and-forward AXI4-Stream packet filter: header mask/value rule plus max-length check.
// Define FILTER_STATS_EN to build the pass/drop statistics counters; otherwise they read 0.
module axis_packet_filter_sf #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic                       s_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic                       m_axis_tlast,
    input  logic [DATA_WIDTH-1:0]      cfg_match_value,
    input  logic [DATA_WIDTH-1:0]      cfg_match_mask,
    input  logic                       cfg_pass_on_match,
    input  logic [$clog2(DEPTH):0]     cfg_max_len,
    output logic [CNT_WIDTH-1:0]       stat_pass_count,
    output logic [CNT_WIDTH-1:0]       stat_drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {HEADER, PAYLOAD, DISCARD} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       wr_ptr, wr_ptr_d;
    logic [PW-1:0]       commit_ptr, commit_ptr_d;
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       len_q, len_d;
    logic [PW-1:0]       max_len_q, max_len_d;
    logic [PW-1:0]       eff_max;
    logic [PW-1:0]       level;
    logic                ready_en;
    logic                full, over, match, keep;
    logic                s_fire, m_fire;
    logic                mem_we, pass_inc, drop_inc;
    logic [DATA_WIDTH:0] mem [DEPTH];

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == PW'(DEPTH));
    assign over    = (len_q + PW'(1)) > max_len_q;
    assign match   = ((s_axis_tdata ^ cfg_match_value) & cfg_match_mask) == '0;
    assign keep    = match ~^ cfg_pass_on_match;
    assign eff_max = (cfg_max_len == '0 || cfg_max_len > PW'(DEPTH)) ? PW'(DEPTH) : cfg_max_len;

    // An oversize beat is never stored, so it may be taken even when the buffer is full;
    // this keeps a DEPTH+1 beat packet from stalling forever against its own uncommitted beats.
    assign s_axis_tready = ready_en &&
                           ((state_q == DISCARD) || !full || (state_q == PAYLOAD && over));
    assign s_fire        = s_axis_tvalid && s_axis_tready;

    assign m_axis_tvalid = (rd_ptr != commit_ptr);
    assign m_fire        = m_axis_tvalid && m_axis_tready;
    assign {m_axis_tlast, m_axis_tdata} = mem[rd_ptr[AW-1:0]];

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr;
        commit_ptr_d = commit_ptr;
        len_d        = len_q;
        max_len_d    = max_len_q;
        mem_we       = 1'b0;
        pass_inc     = 1'b0;
        drop_inc     = 1'b0;
        case (state_q)
            HEADER: begin
                if (s_fire) begin
                    max_len_d = eff_max;
                    if (keep) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr + PW'(1);
                        len_d    = PW'(1);
                        if (s_axis_tlast) begin
                            commit_ptr_d = wr_ptr + PW'(1);
                            pass_inc     = 1'b1;
                        end else begin
                            state_d = PAYLOAD;
                        end
                    end else if (s_axis_tlast) begin
                        drop_inc = 1'b1;
                    end else begin
                        state_d = DISCARD;
                    end
                end
            end
            PAYLOAD: begin
                if (s_fire) begin
                    len_d = len_q + PW'(1);
                    if (over) begin
                        wr_ptr_d = commit_ptr;
                        if (s_axis_tlast) begin
                            drop_inc = 1'b1;
                            state_d  = HEADER;
                        end else begin
                            state_d = DISCARD;
                        end
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr + PW'(1);
                        if (s_axis_tlast) begin
                            commit_ptr_d = wr_ptr + PW'(1);
                            pass_inc     = 1'b1;
                            state_d      = HEADER;
                        end
                    end
                end
            end
            DISCARD: begin
                if (s_fire && s_axis_tlast) begin
                    drop_inc = 1'b1;
                    state_d  = HEADER;
                end
            end
            default: state_d = HEADER;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= HEADER;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            len_q      <= '0;
            max_len_q  <= '0;
            ready_en   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr     <= wr_ptr_d;
            commit_ptr <= commit_ptr_d;
            len_q      <= len_d;
            max_len_q  <= max_len_d;
            ready_en   <= 1'b1;
            if (m_fire)
                rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (mem_we)
            mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end

`ifdef FILTER_STATS_EN
    logic [CNT_WIDTH-1:0] pass_cnt, drop_cnt;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pass_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (pass_inc)
                pass_cnt <= pass_cnt + CNT_WIDTH'(1);
            if (drop_inc)
                drop_cnt <= drop_cnt + CNT_WIDTH'(1);
        end
    end

    assign stat_pass_count = pass_cnt;
    assign stat_drop_count = drop_cnt;
`else
    logic unused_stats;
    assign unused_stats    = pass_inc | drop_inc;
    assign stat_pass_count = '0;
    assign stat_drop_count = '0;
`endif

endmodule

// File: tb/tb_axis_packet_filter_sf.sv
// Scoreboard bench for axis_packet_filter_sf: filter rules, oversize, backpressure, latency, reset.
module tb_axis_packet_filter_sf;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        s_tvalid, s_tready, s_tlast;
    logic [15:0] s_tdata;
    logic        m_tvalid, m_tready, m_tlast;
    logic [15:0] m_tdata;
    logic [15:0] cfg_val, cfg_mask;
    logic        cfg_pass;
    logic [4:0]  cfg_max;
    logic [31:0] pass_cnt, drop_cnt;

`ifdef FILTER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    axis_packet_filter_sf #(
        .DATA_WIDTH(16),
        .DEPTH     (16),
        .CNT_WIDTH (32)
    ) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .s_axis_tvalid    (s_tvalid),
        .s_axis_tready    (s_tready),
        .s_axis_tdata     (s_tdata),
        .s_axis_tlast     (s_tlast),
        .m_axis_tvalid    (m_tvalid),
        .m_axis_tready    (m_tready),
        .m_axis_tdata     (m_tdata),
        .m_axis_tlast     (m_tlast),
        .cfg_match_value  (cfg_val),
        .cfg_match_mask   (cfg_mask),
        .cfg_pass_on_match(cfg_pass),
        .cfg_max_len      (cfg_max),
        .stat_pass_count  (pass_cnt),
        .stat_drop_count  (drop_cnt)
    );

    always #5 aclk = ~aclk;

    int unsigned tests = 0;
    int unsigned failed = 0;
    int unsigned exp_pass = 0;
    int unsigned exp_drop = 0;
    int          cyc = 0;
    bit          lat_mode = 1'b0;
    logic [16:0] sb [$];
    int          lat_q [$];

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor: sampled on the falling edge, the handshake completes on the next rise.
    always @(negedge aclk) begin
        if (aresetn && m_tvalid) begin
            if (sb.size() == 0) begin
                check("extra_beat", 1, 0);
            end else if (m_tready) begin
                check("out_beat", {m_tlast, m_tdata}, sb.pop_front());
                if (lat_mode) begin
                    if (lat_q.size() == 0) check("lat_missing", 1, 0);
                    else check("latency_cyc", 64'(cyc), 64'(lat_q.pop_front()));
                end
            end else begin
                check("hold_beat", {m_tlast, m_tdata}, sb[0]);
            end
        end
    end

    task automatic send_beat(input logic [15:0] d, input logic last,
                             output int acc_cyc, output logic rdy_first);
        int   n;
        logic rdy;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        n = 0;
        @(negedge aclk);
        rdy       = s_tready;
        rdy_first = rdy;
        while (!rdy && n < 1000) begin
            @(negedge aclk);
            rdy = s_tready;
            n++;
        end
        if (!rdy) check("in_timeout", 0, 1);
        @(posedge aclk);
        #1;
        acc_cyc = cyc;
    endtask

    task automatic send_pkt(input logic [15:0] hdr, input int len, input int rdy_from);
        logic [15:0] d [$];
        int          eff, acc;
        logic        rdy, match, pass;
        eff   = (cfg_max == 0 || cfg_max > 16) ? 16 : int'(cfg_max);
        match = ((hdr ^ cfg_val) & cfg_mask) == 16'h0;
        pass  = (match == cfg_pass) && (len <= eff);
        d.push_back(hdr);
        for (int i = 1; i < len; i++) d.push_back(16'($urandom));
        if (pass) begin
            for (int i = 0; i < len; i++) sb.push_back({i == len - 1, d[i]});
            exp_pass++;
        end else begin
            exp_drop++;
        end
        for (int i = 0; i < len; i++) begin
            send_beat(d[i], i == len - 1, acc, rdy);
            if (rdy_from >= 0 && i >= rdy_from) check("in_rdy", rdy, 1);
            if (lat_mode && pass && i == len - 1) lat_q.push_back(acc);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(posedge aclk);
            n++;
        end
        @(posedge aclk);
        #1;
        check("sb_left", 64'(sb.size()), 0);
        check("tvalid_idle", m_tvalid, 0);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_pass"}, pass_cnt, STATS ? 64'(exp_pass) : 64'd0);
        check({tag, "_drop"}, drop_cnt, STATS ? 64'(exp_drop) : 64'd0);
    endtask

    initial begin
        int   acc;
        logic rdy;
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        cfg_val  = 16'hAB00;
        cfg_mask = 16'hFF00;
        cfg_pass = 1'b0;
        cfg_max  = '0;

        #12;
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tready", s_tready, 0);
        check_counts("rst");
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        check("rdy_before_edge", s_tready, 0);
        @(posedge aclk);
        #1;
        check("rdy_after_rst", s_tready, 1);

        // Drop on match
        send_pkt(16'hAB12, 4, -1);
        send_pkt(16'h1234, 3, -1);
        drain();
        check_counts("drop_match");

        // Pass only on match
        cfg_pass = 1'b1;
        send_pkt(16'hAB12, 4, -1);
        send_pkt(16'h1234, 3, -1);
        drain();
        check_counts("pass_only");

        // Oversize: beats 6-8 of the long packet must still be accepted at once
        cfg_max = 5'd5;
        send_pkt(16'hAB12, 8, 5);
        send_pkt(16'hAB34, 5, -1);
        drain();
        check_counts("oversize");

        // Backpressure: two 8-beat packets fill the buffer, third header stalls
        cfg_max  = '0;
        m_tready = 1'b0;
        send_pkt(16'hAB01, 8, -1);
        send_pkt(16'hAB02, 8, -1);
        s_tvalid = 1'b1;
        s_tdata  = 16'hAB03;
        s_tlast  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            check("bp_stall", s_tready, 0);
            @(posedge aclk);
            #1;
        end
        m_tready = 1'b1;
        send_pkt(16'hAB03, 8, -1);
        drain();
        check_counts("backpressure");

        // Single-beat packets back to back
        lat_mode = 1'b1;
        for (int i = 0; i < 8; i++) send_pkt(16'hAB40 + 16'(i), 1, 0);
        drain();
        lat_mode = 1'b0;
        check("lat_left", 64'(lat_q.size()), 0);
        check_counts("single");

        // Reset mid-packet with a committed packet still buffered
        m_tready = 1'b0;
        send_pkt(16'hAB50, 2, -1);
        send_beat(16'hAB60, 1'b0, acc, rdy);
        send_beat(16'h0001, 1'b0, acc, rdy);
        check("pre_rst_tvalid", m_tvalid, 1);
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        sb.delete();
        exp_pass = 0;
        exp_drop = 0;
        #1;
        check("mid_rst_tvalid", m_tvalid, 0);
        check("mid_rst_tready", s_tready, 0);
        check_counts("mid_rst");
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        m_tready = 1'b1;
        send_pkt(16'hAB70, 3, -1);
        drain();
        check_counts("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
